// File: rtl/prf_sequencer_pkg.sv
// Shared constants, state encoding and carrier helpers for the PRF sequencer.
package prf_sequencer_pkg;

    localparam int CNT_W_DEF          = 16;
    localparam int GATE_UNIT_LOG2_DEF = 4;
    localparam int HALF_W             = 6;

    localparam logic [1:0] FREQ_H16 = 2'b00;
    localparam logic [1:0] FREQ_H8  = 2'b01;
    localparam logic [1:0] FREQ_H4  = 2'b10;
    localparam logic [1:0] FREQ_H32 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TX    = 3'd1,
        ST_DELAY = 3'd2,
        ST_GATE  = 3'd3,
        ST_WAIT  = 3'd4
    } state_t;

    // log2 of the carrier half-period in core clocks
    function automatic logic [2:0] half_log2(input logic [1:0] freq);
        case (freq)
            FREQ_H16: return 3'd4;
            FREQ_H8:  return 3'd3;
            FREQ_H4:  return 3'd2;
            FREQ_H32: return 3'd5;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/prf_sequencer_carrier_gen.sv
// Square-wave TX burst generator: H clks positive, H clks negative, per carrier cycle.
module prf_carrier_gen
    import prf_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [HALF_W-1:0] half,
    input  logic [7:0]        bursts,
    output logic              tx_pos,
    output logic              tx_neg,
    output logic              burst_done
);

    logic              active_r;
    logic              neg_r;
    logic              tx_pos_r;
    logic              tx_neg_r;
    logic [HALF_W-1:0] h_r;
    logic [HALF_W-1:0] ph_r;
    logic [7:0]        n_r;
    logic [7:0]        cyc_r;
    logic              last_half_s;

    assign last_half_s = (ph_r == h_r - HALF_W'(1));
    // high during the final clock of the final negative half-cycle
    assign burst_done  = active_r && neg_r && last_half_s && (cyc_r == n_r - 8'd1);
    assign tx_pos      = tx_pos_r;
    assign tx_neg      = tx_neg_r;

    // phase, half-cycle and carrier-cycle counters with registered drives
    always_ff @(posedge clk) begin
        if (reset) begin
            active_r <= 1'b0;
            neg_r    <= 1'b0;
            tx_pos_r <= 1'b0;
            tx_neg_r <= 1'b0;
            h_r      <= '0;
            ph_r     <= '0;
            n_r      <= 8'd0;
            cyc_r    <= 8'd0;
        end else if (start) begin
            active_r <= 1'b1;
            neg_r    <= 1'b0;
            tx_pos_r <= 1'b1;
            tx_neg_r <= 1'b0;
            h_r      <= half;
            ph_r     <= '0;
            n_r      <= bursts;
            cyc_r    <= 8'd0;
        end else if (abort || burst_done) begin
            active_r <= 1'b0;
            tx_pos_r <= 1'b0;
            tx_neg_r <= 1'b0;
        end else if (active_r) begin
            if (last_half_s) begin
                ph_r     <= '0;
                neg_r    <= !neg_r;
                tx_pos_r <= neg_r;
                tx_neg_r <= !neg_r;
                if (neg_r) begin
                    cyc_r <= cyc_r + 8'd1;
                end
            end else begin
                ph_r <= ph_r + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/prf_sequencer.sv
// Per-period scheduler: TX burst, depth delay, sample-volume gate, then wait out the period.
module prf_sequencer
    import prf_sequencer_pkg::*;
#(
    parameter int CNT_W          = CNT_W_DEF,
    parameter int GATE_UNIT_LOG2 = GATE_UNIT_LOG2_DEF
) (
    input  logic             coreClock,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [1:0]       FREQUENCY,
    input  logic [7:0]       BURST_CYCLES,
    input  logic [CNT_W-1:0] DEPTH_DELAY,
    input  logic [7:0]       SV_LENGTH,
    input  logic [CNT_W-1:0] PRF_PERIOD,
    input  logic             STALL,
    output logic             TX_POS,
    output logic             TX_NEG,
    output logic             DEMOD_ON,
    output logic             RETRANSMIT,
    output logic             GATE_DONE,
    output logic             BUSY,
    output logic             CFG_ERR,
    output logic [15:0]      PULSE_COUNT
);

    localparam int SUM_W = CNT_W + 2;

    state_t            state_r;
    logic [CNT_W-1:0]  t_r;
    logic [CNT_W-1:0]  gate_start_r;
    logic [CNT_W-1:0]  gate_end_r;
    logic [CNT_W-1:0]  prf_last_r;
    logic              counted_r;
    logic              demod_r;
    logic              retr_r;
    logic              gdone_r;
    logic              busy_r;
    logic              cfg_err_r;
    logic [15:0]       pulse_count_r;

    logic [2:0]        h_log2_s;
    logic [HALF_W-1:0] half_s;
    logic [SUM_W-1:0]  tb_s;
    logic [SUM_W-1:0]  tg_s;
    logic [SUM_W-1:0]  gs_s;
    logic [SUM_W-1:0]  ge_s;
    logic              cfg_ok_s;
    logic [CNT_W-1:0]  t_next_s;
    logic              period_end_s;
    logic              attempt_s;
    logic              start_s;
    logic              abort_s;
    logic              burst_done_s;

    // Validity is judged on the live inputs, which are exactly what gets latched on start.
    assign h_log2_s     = half_log2(FREQUENCY);
    assign half_s       = HALF_W'(1) << h_log2_s;
    assign tb_s         = SUM_W'(BURST_CYCLES) << (h_log2_s + 3'd1);
    assign tg_s         = SUM_W'(SV_LENGTH) << GATE_UNIT_LOG2;
    assign gs_s         = tb_s + SUM_W'(DEPTH_DELAY);
    assign ge_s         = gs_s + tg_s;
    assign cfg_ok_s     = (BURST_CYCLES != 8'd0) && (SV_LENGTH != 8'd0) &&
                          (ge_s < SUM_W'(PRF_PERIOD));

    assign t_next_s     = t_r + CNT_W'(1);
    assign period_end_s = (state_r == ST_WAIT) && (t_r == prf_last_r);
    assign attempt_s    = ENABLE && !STALL && ((state_r == ST_IDLE) || period_end_s);
    assign start_s      = attempt_s && cfg_ok_s;
    assign abort_s      = !ENABLE &&
                          ((state_r == ST_TX) || (state_r == ST_DELAY) || (state_r == ST_GATE));

    prf_carrier_gen u_carrier (
        .clk        (coreClock),
        .reset      (RESET),
        .start      (start_s),
        .abort      (abort_s),
        .half       (half_s),
        .bursts     (BURST_CYCLES),
        .tx_pos     (TX_POS),
        .tx_neg     (TX_NEG),
        .burst_done (burst_done_s)
    );

    // period FSM, shadow configuration, status and pulse counter
    always_ff @(posedge coreClock) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            t_r           <= '0;
            gate_start_r  <= '0;
            gate_end_r    <= '0;
            prf_last_r    <= '0;
            counted_r     <= 1'b0;
            demod_r       <= 1'b0;
            retr_r        <= 1'b0;
            gdone_r       <= 1'b0;
            busy_r        <= 1'b0;
            cfg_err_r     <= 1'b0;
            pulse_count_r <= 16'd0;
        end else begin
            retr_r  <= 1'b0;
            gdone_r <= 1'b0;
            // a stalled period is counted once, when it first reaches its last clock
            if (period_end_s && !counted_r) begin
                pulse_count_r <= pulse_count_r + 16'd1;
                counted_r     <= 1'b1;
            end
            if (start_s) begin
                state_r      <= ST_TX;
                busy_r       <= 1'b1;
                t_r          <= '0;
                retr_r       <= 1'b1;
                cfg_err_r    <= 1'b0;
                counted_r    <= 1'b0;
                gate_start_r <= gs_s[CNT_W-1:0];
                gate_end_r   <= ge_s[CNT_W-1:0];
                prf_last_r   <= PRF_PERIOD - CNT_W'(1);
            end else if (attempt_s) begin
                state_r   <= ST_IDLE;
                busy_r    <= 1'b0;
                cfg_err_r <= 1'b1;
            end else if (abort_s) begin
                state_r <= ST_IDLE;
                busy_r  <= 1'b0;
                demod_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        busy_r <= 1'b0;
                    end
                    ST_TX: begin
                        t_r <= t_next_s;
                        if (burst_done_s) begin
                            if (t_next_s == gate_start_r) begin
                                state_r <= ST_GATE;
                                demod_r <= 1'b1;
                            end else begin
                                state_r <= ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        t_r <= t_next_s;
                        if (t_next_s == gate_start_r) begin
                            state_r <= ST_GATE;
                            demod_r <= 1'b1;
                        end
                    end
                    ST_GATE: begin
                        t_r <= t_next_s;
                        if (t_next_s == gate_end_r) begin
                            state_r <= ST_WAIT;
                            demod_r <= 1'b0;
                            gdone_r <= 1'b1;
                        end
                    end
                    ST_WAIT: begin
                        if (!period_end_s) begin
                            t_r <= t_next_s;
                        end else if (!ENABLE) begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        demod_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign DEMOD_ON    = demod_r;
    assign RETRANSMIT  = retr_r;
    assign GATE_DONE   = gdone_r;
    assign BUSY        = busy_r;
    assign CFG_ERR     = cfg_err_r;
    assign PULSE_COUNT = pulse_count_r;

endmodule

// File: tb/tb_prf_sequencer.sv
// Directed self-checking bench for prf_sequencer: configuration table plus corner-case sequences.
module tb_prf_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        stall;
    logic [1:0]  freq;
    logic [7:0]  burst;
    logic [15:0] depth;
    logic [7:0]  sv;
    logic [15:0] prf;
    logic        tx_pos, tx_neg, demod_on, retransmit, gate_done, busy, cfg_err;
    logic [15:0] pulse_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int freq; int burst; int depth; int sv; int prf;
        int valid; int h; int tb; int gs; int gl;
    } vec_t;

    vec_t tbl [9];

    always #5 clk = ~clk;

    prf_sequencer dut (
        .coreClock    (clk),
        .RESET        (reset),
        .ENABLE       (enable),
        .FREQUENCY    (freq),
        .BURST_CYCLES (burst),
        .DEPTH_DELAY  (depth),
        .SV_LENGTH    (sv),
        .PRF_PERIOD   (prf),
        .STALL        (stall),
        .TX_POS       (tx_pos),
        .TX_NEG       (tx_neg),
        .DEMOD_ON     (demod_on),
        .RETRANSMIT   (retransmit),
        .GATE_DONE    (gate_done),
        .BUSY         (busy),
        .CFG_ERR      (cfg_err),
        .PULSE_COUNT  (pulse_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] obs();
        return {retransmit, tx_pos, tx_neg, demod_on, gate_done, busy};
    endfunction

    task automatic set_cfg(input int f, input int b, input int d, input int s, input int p);
        freq  = 2'(f);
        burst = 8'(b);
        depth = 16'(d);
        sv    = 8'(s);
        prf   = 16'(p);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        stall  = 1'b0;
        tick();
        reset  = 1'b0;
    endtask

    task automatic wait_retrans(input int bound);
        int n = 0;
        while (!retransmit && n < bound) begin
            tick();
            n++;
        end
        chk("retrans_start", 32'(retransmit), 32'd1);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [5:0] e;
        int cnt;
        int seen;

        //            freq burst depth  sv  prf    valid h   tb     gs  gl
        tbl[0] = '{1, 2,   10,    1,   100,   1,  8,  32,    42, 16};
        tbl[1] = '{0, 1,   0,     2,   65,    1,  16, 32,    32, 32};
        tbl[2] = '{2, 3,   5,     1,   50,    1,  4,  24,    29, 16};
        tbl[3] = '{3, 1,   3,     1,   84,    1,  32, 64,    67, 16};
        tbl[4] = '{1, 2,   60,    1,   100,   0,  8,  32,    92, 16};
        tbl[5] = '{1, 0,   10,    1,   100,   0,  8,  0,     10, 16};
        tbl[6] = '{1, 2,   10,    0,   100,   0,  8,  32,    42, 0};
        tbl[7] = '{1, 2,   10,    1,   58,    0,  8,  32,    42, 16};
        tbl[8] = '{3, 255, 65535, 255, 65535, 0,  32, 16320, 0,  4080};

        set_cfg(1, 2, 10, 1, 100);
        reset = 1'b1; enable = 1'b0; stall = 1'b0;
        tick();
        tick();
        chk("reset_outputs", 32'(obs()), 32'd0);
        chk("reset_cfg_err", 32'(cfg_err), 32'd0);
        chk("reset_count", 32'(pulse_count), 32'd0);

        // table: one full period per valid entry, refusal per invalid entry
        for (int k = 0; k < 9; k++) begin
            do_reset();
            set_cfg(tbl[k].freq, tbl[k].burst, tbl[k].depth, tbl[k].sv, tbl[k].prf);
            enable = 1'b1;
            if (tbl[k].valid != 0) begin
                wait_retrans(4);
                for (int t = 0; t < tbl[k].prf; t++) begin
                    e[5] = (t == 0);
                    e[4] = (t < tbl[k].tb) && ((t % (2 * tbl[k].h)) < tbl[k].h);
                    e[3] = (t < tbl[k].tb) && ((t % (2 * tbl[k].h)) >= tbl[k].h);
                    e[2] = (t >= tbl[k].gs) && (t < tbl[k].gs + tbl[k].gl);
                    e[1] = (t == tbl[k].gs + tbl[k].gl);
                    e[0] = 1'b1;
                    chk($sformatf("vec%0d_t%0d", k, t), 32'(obs()), 32'(e));
                    tick();
                end
                chk($sformatf("vec%0d_next_retrans", k), 32'(retransmit), 32'd1);
                chk($sformatf("vec%0d_count", k), 32'(pulse_count), 32'd1);
                chk($sformatf("vec%0d_cfg_err", k), 32'(cfg_err), 32'd0);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    tick();
                    chk($sformatf("vec%0d_idle%0d", k, i), 32'(obs()), 32'd0);
                end
                chk($sformatf("vec%0d_cfg_err", k), 32'(cfg_err), 32'd1);
            end
        end

        // invalid configuration repaired in IDLE
        do_reset();
        set_cfg(1, 2, 60, 1, 100);
        enable = 1'b1;
        run_ticks(3);
        chk("inv_cfg_err", 32'(cfg_err), 32'd1);
        chk("inv_busy", 32'(busy), 32'd0);
        prf = 16'd200;
        tick();
        chk("fix_retrans", 32'(retransmit), 32'd1);
        chk("fix_cfg_err", 32'(cfg_err), 32'd0);
        chk("fix_busy", 32'(busy), 32'd1);

        // backpressure: STALL during GATE is ignored, STALL at period end holds WAIT
        do_reset();
        set_cfg(1, 2, 10, 1, 100);
        enable = 1'b1;
        wait_retrans(4);
        cnt = 0;
        for (int t = 0; t < 100; t++) begin
            cnt += int'(demod_on);
            if (t == 45) stall = 1'b1;
            if (t == 48) stall = 1'b0;
            if (t == 99) stall = 1'b1;
            tick();
        end
        chk("stall_gate_width", 32'(cnt), 32'd16);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (obs() != 6'b000001) seen++;
            if (i == 24) stall = 1'b0;
            tick();
        end
        chk("stall_hold_bad_cycles", 32'(seen), 32'd0);
        chk("stall_release_retrans", 32'(retransmit), 32'd1);
        chk("stall_count", 32'(pulse_count), 32'd1);

        // abort inside TX
        do_reset();
        set_cfg(1, 2, 10, 1, 100);
        enable = 1'b1;
        wait_retrans(4);
        run_ticks(20);
        chk("abort_tx_pos_t20", 32'(tx_pos), 32'd1);
        enable = 1'b0;
        tick();
        chk("abort_t21", 32'({tx_pos, tx_neg, busy}), 32'd0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (gate_done || demod_on || retransmit) seen++;
            tick();
        end
        chk("abort_quiet", 32'(seen), 32'd0);
        chk("abort_count", 32'(pulse_count), 32'd0);

        // SV_LENGTH change mid-gate takes effect next period, then reset mid-DELAY
        do_reset();
        set_cfg(1, 2, 10, 1, 100);
        enable = 1'b1;
        wait_retrans(4);
        cnt = 0;
        for (int t = 0; t < 100; t++) begin
            cnt += int'(demod_on);
            if (t == 45) sv = 8'd3;
            tick();
        end
        chk("shadow_gate1", 32'(cnt), 32'd16);
        chk("shadow_retrans2", 32'(retransmit), 32'd1);
        cnt = 0;
        for (int t = 0; t < 100; t++) begin
            cnt += int'(demod_on);
            tick();
        end
        chk("shadow_gate2", 32'(cnt), 32'd48);
        chk("shadow_count", 32'(pulse_count), 32'd2);
        run_ticks(35);
        chk("delay_state", 32'(obs()), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("srst_outputs", 32'(obs()), 32'd0);
        chk("srst_count", 32'(pulse_count), 32'd0);
        chk("srst_cfg_err", 32'(cfg_err), 32'd0);

        // pulse counter wrap with a minimal 25-clk period
        do_reset();
        set_cfg(2, 1, 0, 1, 25);
        enable = 1'b1;
        wait_retrans(4);
        run_ticks(5);
        force dut.pulse_count_r = 16'hFFFF;
        tick();
        release dut.pulse_count_r;
        tick();
        chk("wrap_preload", 32'(pulse_count), 32'h0000FFFF);
        run_ticks(18);
        chk("wrap_retrans", 32'(retransmit), 32'd1);
        chk("wrap_count", 32'(pulse_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prf_sequencer.md
Name: prf_sequencer

Overview:
- Per-pulse-repetition-period scheduler for the Doppler front end.
- Each period it fires a TX burst on the carrier, waits the programmed depth delay, then opens the sample-volume gate that enables demodulation.
- Holds the loop off when storage backpressures.
- Sits between MemoryMap (configuration) and Demodulate/Storeage (DEMOD_ON, RETRANSMIT); replaces the ad-hoc period timing in the core layer.

Parameters:
- CNT_W, 16, width of period/delay counters.
- GATE_UNIT_LOG2, 4, gate length unit = 2^4 = 16 coreClock cycles.

Ports:
- coreClock  input  1  64 MHz core clock; sole clock.
- RESET  input  1  synchronous, active-high reset.
- ENABLE  input  1  run request (from MemoryMap RUN).
- FREQUENCY  input  2  carrier select: 00→half-period 16 clk, 01→8, 10→4, 11→32.
- BURST_CYCLES  input  8  carrier cycles per burst; 0 is invalid.
- DEPTH_DELAY  input  CNT_W  clk cycles from end of burst to gate open.
- SV_LENGTH  input  8  gate length in 16-clk units; 0 is invalid.
- PRF_PERIOD  input  CNT_W  period length in clk cycles.
- STALL  input  1  storage almost-full; blocks the start of a new period.
- TX_POS  output  1  positive transmit drive.
- TX_NEG  output  1  negative transmit drive.
- DEMOD_ON  output  1  sample-volume gate.
- RETRANSMIT  output  1  one-cycle pulse at each period start (demod accumulator reset).
- GATE_DONE  output  1  one-cycle pulse on the cycle after the gate closes.
- BUSY  output  1  state != IDLE.
- CFG_ERR  output  1  sticky; last latch attempt had an invalid configuration.
- PULSE_COUNT  output  16  completed periods; wraps at 65535→0.

Behaviour:
- Reset: all outputs 0, PULSE_COUNT=0, CFG_ERR=0, state IDLE. Reset dominates every other input.
- Shadow registers: all configuration inputs are latched only in the IDLE→TX transition and at each WAIT→TX transition. Changes mid-period have no effect until the next period.
- Derived values, computed from shadow inputs:
  - H = half-period per FREQUENCY.
  - Tb = BURST_CYCLES*2H.
  - Tg = SV_LENGTH*16.
- Validity: BURST_CYCLES!=0, SV_LENGTH!=0, and Tb+DEPTH_DELAY+Tg < PRF_PERIOD. Evaluate the sum at 18 bits; no overflow is allowed.
- Invalid config at a latch point: set CFG_ERR, go/stay IDLE, emit no RETRANSMIT. CFG_ERR clears on the next successful latch or on RESET.
- Period counter t: 0 on the RETRANSMIT cycle, +1 each clk.
- States:
  - IDLE: outputs low. Go to TX when ENABLE && !STALL && config valid; that cycle pulses RETRANSMIT and sets t=0.
  - TX, t in [0,Tb):
    - TX_POS=1 for the first H clks of each carrier cycle, TX_NEG=1 for the second H.
    - TX_POS and TX_NEG are never high together and both are registered.
    - At t=Tb-1 go to DELAY.
  - DELAY: outputs low. Lasts DEPTH_DELAY clks. DEPTH_DELAY=0 goes straight to GATE.
  - GATE: DEMOD_ON=1 for exactly Tg clks, from t=Tb+DEPTH_DELAY to t=Tb+DEPTH_DELAY+Tg-1. On exit pulse GATE_DONE.
  - WAIT: outputs low until t=PRF_PERIOD-1, then PULSE_COUNT++.
    - If ENABLE && !STALL && config valid: start the next period (RETRANSMIT) on the following cycle, giving back-to-back periods of exactly PRF_PERIOD clks.
    - If STALL: hold in WAIT with t frozen at PRF_PERIOD-1 until STALL falls; no period is dropped silently.
    - If !ENABLE: go IDLE.
- ENABLE low mid-period (TX/DELAY/GATE): abort on the next cycle. TX_*/DEMOD_ON go low in that cycle, no GATE_DONE, PULSE_COUNT unchanged, state IDLE.
- STALL is sampled only at period start. STALL asserted during TX/DELAY/GATE does not disturb the current period.
- RETRANSMIT and GATE_DONE never coincide (WAIT ≥ 1 clk is guaranteed by the strict < check).

Decomposition:
- Shared defines file (Defines.v): FREQUENCY→half-period encoding constants; state encodings IDLE/TX/DELAY/GATE/WAIT; gate unit constant.
- One sub-module: prf_carrier_gen. Inputs: H and burst count. Outputs: TX_POS/TX_NEG and burst_done.
- The FSM, counters, validity check and PULSE_COUNT stay in prf_sequencer.

Test Plan:
- Nominal run: FREQUENCY=01, BURST=2, DEPTH=10, SV=1, PRF=100, ENABLE=1.
  - RETRANSMIT at t=0.
  - TX_POS at t 0-7 and 16-23; TX_NEG at t 8-15 and 24-31.
  - DEMOD_ON at t 42-57; GATE_DONE at t=58.
  - Next RETRANSMIT exactly 100 clks later; PULSE_COUNT=1 after the first period.
- Invalid config: BURST=2 (Tb=32), DEPTH=60, SV=1, PRF=100.
  - Sum 108 ≥ 100, so CFG_ERR=1, BUSY=0, no TX activity.
  - Fix PRF=200: CFG_ERR clears and a period starts.
- Backpressure: STALL=1 at the end of period 1 for 25 clks.
  - Outputs low and state WAIT for those 25 clks.
  - RETRANSMIT one clk after STALL falls.
  - Toggling STALL during GATE does not change the DEMOD_ON width.
- Abort: ENABLE drops at t=20 (inside TX).
  - TX_POS and TX_NEG both 0 by t=21; no GATE_DONE; PULSE_COUNT unchanged; BUSY=0.
- Config shadowing and sync reset:
  - Change SV_LENGTH 1→3 mid-GATE: current gate stays 16 clks, the next period's gate is 48 clks.
  - Assert RESET for 1 clk mid-DELAY: all outputs 0 the next cycle, PULSE_COUNT=0.
- Counter wrap: preload by running 65535 minimal periods (or force) → next completion reads PULSE_COUNT=0.
